// File: rtl/tone_generator.sv
// Square-wave tone source for a stereo audio codec, one tone of SAMPLES_PER_TONE samples per start.
// Latency: write strobes one edge after write_ready is seen high with write low; busy/done follow state directly.
// Backpressure: a sample is pushed only when write_ready=1; write is never high on two consecutive cycles.
//
// Ports: clk/resetn (async active-low), start/stop control, freq[15:0] Hz and amp[22:0] captured at start,
// write_ready from the codec FIFO, write strobe with writedata_left/right[23:0] samples, busy (PLAY), done (DONE).
// Build option: define TONE_GENERATOR_STEREO_EN to mirror the left sample onto the right channel;
// otherwise the right channel is held at 0.
module tone_generator #(
    // Samples per tone; 48000 gives 1 s at the codec's 48 kHz rate.
    parameter int unsigned SAMPLES_PER_TONE = 48000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] freq,
    input  logic [22:0] amp,
    input  logic        write_ready,
    output logic        write,
    output logic [23:0] writedata_left,
    output logic [23:0] writedata_right,
    output logic        busy,
    output logic        done
);

    // Half the sample rate: the accumulator counts in Hz against this, so a
    // polarity flip happens every 24000/freq samples (freq/2 full cycles per 24000).
    localparam logic [15:0] FREQ_MAX    = 16'd24000;
    localparam logic [15:0] SAMPLE_LOAD = 16'(SAMPLES_PER_TONE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] freq_c;
    logic [22:0] amp_c;
    logic [15:0] acc;
    logic [15:0] cnt;
    logic        pol_neg;

    logic        start_ok;
    logic        write_nxt;
    logic [15:0] acc_sum;
    logic        wrap;
    logic [23:0] amp_pos;
    logic [23:0] sample;

    // start is honoured only outside PLAY, and stop always wins over it.
    assign start_ok  = start && !stop && ((state == IDLE) || (state == DONE));

    // The !write term enforces a gap cycle between strobes; cnt==0 stops
    // issuing once the last sample of the tone has gone out.
    assign write_nxt = (state == PLAY) && !stop && write_ready && !write && (cnt != 16'd0);

    // acc < 24000 and freq_c <= 24000, so the sum peaks at 47999 and fits 16 bits.
    assign acc_sum   = acc + freq_c;
    assign wrap      = (acc_sum >= FREQ_MAX);
    assign amp_pos   = {1'b0, amp_c};

    always_comb begin
        sample = 24'd0;
        if (freq_c != 16'd0) begin
            sample = pol_neg ? (~amp_pos + 24'd1) : amp_pos;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = PLAY;
                end
            end
            PLAY: begin
                busy = 1'b1;
                // cnt already reached 0 on the edge that raised the final strobe.
                if (write && (cnt == 16'd0)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start_ok) begin
                    state_nxt = PLAY;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (stop) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            write          <= 1'b0;
            writedata_left <= 24'd0;
            freq_c         <= 16'd0;
            amp_c          <= 23'd0;
            acc            <= 16'd0;
            cnt            <= 16'd0;
            pol_neg        <= 1'b0;
        end else begin
            write <= write_nxt;
            if (start_ok) begin
                freq_c  <= (freq > FREQ_MAX) ? FREQ_MAX : freq;
                amp_c   <= amp;
                cnt     <= SAMPLE_LOAD;
                acc     <= 16'd0;
                pol_neg <= 1'b0;
            end else if (write_nxt) begin
                // The sample carries the polarity in force before this step's update.
                writedata_left <= sample;
                cnt            <= cnt - 16'd1;
                if (wrap) begin
                    acc     <= acc_sum - FREQ_MAX;
                    pol_neg <= !pol_neg;
                end else begin
                    acc     <= acc_sum;
                end
            end
        end
    end

`ifdef TONE_GENERATOR_STEREO_EN
    assign writedata_right = writedata_left;
`else
    assign writedata_right = 24'd0;
`endif

endmodule

// File: tb/tb_tone_generator.sv
module tb_tone_generator;

    localparam int N = 480;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        stop;
    logic [15:0] freq;
    logic [22:0] amp;
    logic        write_ready;
    logic        write;
    logic [23:0] writedata_left;
    logic [23:0] writedata_right;
    logic        busy;
    logic        done;

    logic        ready_level;
    logic        rand_ready;

    logic [23:0] sb_q[$];
    int          errors   = 0;
    int          checks   = 0;
    int          n_writes = 0;
    logic        prev_write = 1'b0;
    logic [23:0] last_left  = 24'd0;
    logic [23:0] exp_val;
    logic [23:0] exp_r;

    tone_generator #(.SAMPLES_PER_TONE(N)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .start           (start),
        .stop            (stop),
        .freq            (freq),
        .amp             (amp),
        .write_ready     (write_ready),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Single driver for write_ready: held level or ~30% random duty.
    always @(posedge clk) begin
        #2;
        write_ready = rand_ready ? ($urandom_range(99) < 30) : ready_level;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every strobe, checks spacing, hold and right channel.
    always @(negedge clk) begin
        if (!resetn) begin
            last_left  = 24'd0;
            prev_write = 1'b0;
        end else begin
`ifdef TONE_GENERATOR_STEREO_EN
            exp_r = writedata_left;
`else
            exp_r = 24'd0;
`endif
            chk("right_channel", writedata_right, exp_r);
            if (write) begin
                chk("no_back_to_back", prev_write, 1'b0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got data %0h with no sample expected", writedata_left);
                end else begin
                    exp_val = sb_q.pop_front();
                    chk($sformatf("sample_%0d", n_writes), writedata_left, exp_val);
                end
                n_writes++;
                last_left = writedata_left;
            end else begin
                chk("hold_left", writedata_left, last_left);
            end
            prev_write = write;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected waveform: polarity flips every 'half' samples; half=0 means silence.
    task automatic push_tone(input logic [22:0] a, input int half, input int count);
        logic [23:0] pos;
        logic [23:0] neg;
        pos = {1'b0, a};
        neg = ~pos + 24'd1;
        for (int i = 0; i < count; i++) begin
            if (half == 0)
                sb_q.push_back(24'd0);
            else
                sb_q.push_back((((i / half) % 2) == 0) ? pos : neg);
        end
    endtask

    task automatic start_tone(input logic [15:0] f, input logic [22:0] a);
        freq  = f;
        amp   = a;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_done_low", done, 1'b0);
    endtask

    task automatic run_to_done(input string name, input int base);
        int t;
        t = 0;
        while (done !== 1'b1 && t < 40 * N) begin
            step();
            t++;
        end
        chk({name, "_done"}, done, 1'b1);
        chk({name, "_busy_low"}, busy, 1'b0);
        chk({name, "_write_count"}, n_writes - base, N);
        chk({name, "_queue_empty"}, sb_q.size(), 0);
    endtask

    task automatic wait_writes(input string name, input int target);
        int t;
        t = 0;
        while (n_writes < target && t < 40 * N) begin
            step();
            t++;
        end
        chk(name, n_writes, target);
    endtask

    initial begin
        int base;
        resetn      = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        freq        = 16'd0;
        amp         = 23'd0;
        ready_level = 1'b1;
        rand_ready  = 1'b0;
        write_ready = 1'b0;
        step(3);
        chk("rst_write", write, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_left", writedata_left, 24'd0);
        chk("rst_right", writedata_right, 24'd0);
        resetn = 1'b1;
        step(2);

        // start and stop together from IDLE: stop wins
        freq  = 16'd1000;
        amp   = 23'd100;
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop_busy", busy, 1'b0);
        chk("startstop_done", done, 1'b0);
        step(4);
        chk("startstop_still_idle", busy, 1'b0);
        chk("startstop_no_write", n_writes, 0);

        // 1000 Hz, ready held; input changes and start during PLAY are ignored
        base = n_writes;
        push_tone(23'd100000, 24, N);
        start_tone(16'd1000, 23'd100000);
        step(20);
        freq  = 16'd5000;
        amp   = 23'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("play_start_ignored_busy", busy, 1'b1);
        run_to_done("tone_1k", base);
        step(5);
        chk("done_persists", done, 1'b1);

        // silence at freq 0, started from DONE
        base = n_writes;
        push_tone(23'd5000, 0, N);
        start_tone(16'd0, 23'd5000);
        run_to_done("tone_zero", base);

        // 30000 Hz clamps to 24000: flip every sample
        base = n_writes;
        push_tone(23'd4321, 1, N);
        start_tone(16'd30000, 23'd4321);
        run_to_done("tone_clamp", base);

        // 1000 Hz with ~30% write_ready: same waveform
        rand_ready = 1'b1;
        base = n_writes;
        push_tone(23'd100000, 24, N);
        start_tone(16'd1000, 23'd100000);
        run_to_done("tone_rand", base);
        rand_ready = 1'b0;
        step(2);

        // stop after write #100
        base = n_writes;
        push_tone(23'd100000, 24, 100);
        start_tone(16'd1000, 23'd100000);
        wait_writes("stop_reach_100", base + 100);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_busy", busy, 1'b0);
        chk("stop_done", done, 1'b0);
        chk("stop_write", write, 1'b0);
        step(10);
        chk("stop_no_more_writes", n_writes - base, 100);
        chk("stop_queue_empty", sb_q.size(), 0);

        // fresh tone after stop begins positive
        base = n_writes;
        push_tone(23'd777, 24, N);
        start_tone(16'd1000, 23'd777);
        run_to_done("tone_after_stop", base);

        // asynchronous reset mid-PLAY
        base = n_writes;
        push_tone(23'd100000, 24, 50);
        start_tone(16'd1000, 23'd100000);
        wait_writes("rst_reach_50", base + 50);
        resetn = 1'b0;
        #1;
        chk("midrst_write", write, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_left", writedata_left, 24'd0);
        chk("midrst_right", writedata_right, 24'd0);
        step(2);
        resetn = 1'b1;
        step(10);
        chk("midrst_no_more_writes", n_writes - base, 50);
        chk("midrst_idle", busy, 1'b0);
        chk("midrst_queue_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
